// File: rtl/fir_pkg.sv
// Shared widths, fir_core load encodings and loader state enum.
// Latency: n/a (types only); backpressure: n/a.
package fir_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 14;
   localparam int BLK_W  = 5;
   localparam int OFF_W  = 9;

   localparam logic [1:0] DLOAD_WR   = 2'b00;
   localparam logic [1:0] DLOAD_RD   = 2'b01;
   localparam logic [1:0] DLOAD_IDLE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COEF = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/fir_addr_cnt.sv
// Block/offset word counter; offset wraps at DEPTH-1 and carries into block.
// Latency: count updates one cycle after inc; clear wins over inc; no backpressure.
module fir_addr_cnt
   import fir_pkg::*;
#(
   parameter int DEPTH = 512
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   input  logic [BLK_W-1:0] last_blk,
   input  logic [OFF_W-1:0] last_off,
   output logic [BLK_W-1:0] blk,
   output logic [OFF_W-1:0] off,
   output logic             tc
);

   localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(DEPTH - 1);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         blk <= '0;
         off <= '0;
      end else if (inc) begin
         if (off == OFF_MAX) begin
            off <= '0;
            blk <= blk + 1'b1;
         end else begin
            off <= off + 1'b1;
         end
      end
   end

   assign tc = (blk == last_blk) && (off == last_off);

endmodule

// File: rtl/fir_loader.sv
// Streams coefficients then samples into fir_core CMEM/IMEM; writes appear one cycle after handshake.
// Backpressure: s_ready only in COEF/DATA and never while abort is asserted.
module fir_loader
   import fir_pkg::*;
#(
   parameter int NUM_COEFS   = 64,
   parameter int NUM_SAMPLES = 10000,
   parameter int BLOCK_DEPTH = 512
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [15:0] s_data,
   output logic [15:0] f_din,
   output logic [13:0] f_addr,
   output logic [1:0]  f_dload,
   output logic        f_cload,
   output logic        busy,
   output logic        done
);

   localparam logic [BLK_W-1:0] COEF_LAST_BLK = BLK_W'((NUM_COEFS - 1) / BLOCK_DEPTH);
   localparam logic [OFF_W-1:0] COEF_LAST_OFF = OFF_W'((NUM_COEFS - 1) % BLOCK_DEPTH);
   localparam logic [BLK_W-1:0] DATA_LAST_BLK = BLK_W'((NUM_SAMPLES - 1) / BLOCK_DEPTH);
   localparam logic [OFF_W-1:0] DATA_LAST_OFF = OFF_W'((NUM_SAMPLES - 1) % BLOCK_DEPTH);

   state_t           state;
   state_t           state_nxt;
   logic             hs;
   logic             cnt_clr;
   logic             cnt_tc;
   logic [BLK_W-1:0] blk;
   logic [OFF_W-1:0] off;
   logic [BLK_W-1:0] last_blk;
   logic [OFF_W-1:0] last_off;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_COEF;
         ST_COEF: begin
            if (abort)             state_nxt = ST_IDLE;
            else if (hs && cnt_tc) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (abort)             state_nxt = ST_IDLE;
            else if (hs && cnt_tc) state_nxt = ST_DONE;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The counter is shared: cleared on the last coefficient so samples restart at {0,0}.
   always_comb begin
      busy     = (state == ST_COEF) || (state == ST_DATA);
      done     = (state == ST_DONE);
      s_ready  = busy && !abort;
      hs       = s_valid && s_ready;
      cnt_clr  = (busy && abort) || (hs && cnt_tc);
      last_blk = (state == ST_COEF) ? COEF_LAST_BLK : DATA_LAST_BLK;
      last_off = (state == ST_COEF) ? COEF_LAST_OFF : DATA_LAST_OFF;
   end

   fir_addr_cnt #(
      .DEPTH    (BLOCK_DEPTH)
   ) u_addr_cnt (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .inc      (hs),
      .last_blk (last_blk),
      .last_off (last_off),
      .blk      (blk),
      .off      (off),
      .tc       (cnt_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         f_din   <= '0;
         f_addr  <= '0;
         f_dload <= DLOAD_IDLE;
         f_cload <= 1'b0;
      end else begin
         f_cload <= hs && (state == ST_COEF);
         f_dload <= (hs && (state == ST_DATA)) ? DLOAD_WR : DLOAD_IDLE;
         if (hs) begin
            f_din  <= s_data;
            f_addr <= {blk, off};
         end
      end
   end

   // Read mode belongs to fir_core's own sequencer; the loader must never request it.
   always_ff @(posedge clk) begin
      if (!reset) assert (f_dload != DLOAD_RD);
   end

endmodule

// File: tb/tb_fir_loader.sv
// Randomized bench for fir_loader: a negedge monitor logs every fir_core write, tasks
// compare the log against the word stream and the block/offset addressing rule.
module tb_fir_loader;

   localparam int NC = 64;
   localparam int NS = 10000;
   localparam int BD = 512;
   localparam int NW = NC + NS;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_data = '0;
   logic [15:0] f_din;
   logic [13:0] f_addr;
   logic [1:0]  f_dload;
   logic        f_cload;
   logic        busy;
   logic        done;

   fir_loader #(
      .NUM_COEFS   (NC),
      .NUM_SAMPLES (NS),
      .BLOCK_DEPTH (BD)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .abort   (abort),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .f_din   (f_din),
      .f_addr  (f_addr),
      .f_dload (f_dload),
      .f_cload (f_cload),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_data;
      logic [13:0] addr;
      logic [15:0] dat;
      int          cyc;
   } wr_t;

   wr_t         wq[$];
   int          hsq[$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          odd_cnt = 0;
   int          total = 0;
   int          bad = 0;
   int          last_wb = 0;
   logic [15:0] stim[NW];
   logic [15:0] cimg[NC];
   logic [15:0] dimg[16384];
   bit          dseen[16384];
   bit          cseen[NC];

   always @(posedge clk) cyc <= cyc + 1;

   // Write log: one entry per strobe cycle, plus the cycle each handshake happens.
   always @(negedge clk) begin
      if (f_cload === 1'b1 || f_dload === 2'b00)
         wq.push_back('{is_data: (f_dload === 2'b00), addr: f_addr, dat: f_din, cyc: cyc});
      if ((f_cload === 1'b1 && f_dload !== 2'b11) || f_dload === 2'b01 || f_dload === 2'b10)
         odd_cnt <= odd_cnt + 1;
      if (done === 1'b1) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (s_valid === 1'b1 && s_ready === 1'b1 && reset === 1'b0)
         hsq.push_back(cyc);
   end

   // Expected address for stream word k: coefficient index, or {sample/BD, sample%BD}.
   function automatic logic [13:0] exp_addr(input int k);
      logic [4:0] b;
      logic [8:0] o;
      if (k < NC) return 14'(k);
      b = 5'((k - NC) / BD);
      o = 9'((k - NC) % BD);
      return {b, o};
   endfunction

   task automatic fill_stim();
      for (int i = 0; i < NW; i++) stim[i] = 16'($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Presents stim[first..last_excl-1]; at word stop_at asserts abort (or reset) with s_valid.
   task automatic drive(input int first, input int last_excl, input int pct,
                        input int stop_at, input bit stop_reset);
      int i = first;
      int cycles = 0;
      bit hs;
      bit stopped = 1'b0;
      while (i < last_excl && !stopped && cycles < 40000) begin
         if (i == stop_at) begin
            s_valid = 1'b1;
            s_data  = stim[i];
            if (stop_reset) reset = 1'b1;
            else            abort = 1'b1;
            @(posedge clk); #1;
            reset   = 1'b0;
            abort   = 1'b0;
            s_valid = 1'b0;
            stopped = 1'b1;
         end else begin
            s_valid = ($urandom_range(99) < pct);
            s_data  = s_valid ? stim[i] : 16'($urandom);
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            if (hs) i++;
            cycles++;
         end
      end
      s_valid = 1'b0;
      total++;
      if (cycles >= 40000) begin
         bad++;
         $display("FAIL drive_budget: accepted %0d words, required %0d", i - first, last_excl - first);
      end
   endtask

   task automatic test_reset();
      int strobes = 0;
      int rdy = 0;
      int db;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      total++; if (f_din !== 16'h0)   begin bad++; $display("FAIL reset_f_din: got %h need 0000", f_din); end
      total++; if (f_addr !== 14'h0)  begin bad++; $display("FAIL reset_f_addr: got %h need 0000", f_addr); end
      total++; if (f_dload !== 2'b11) begin bad++; $display("FAIL reset_f_dload: got %b need 11", f_dload); end
      total++; if (f_cload !== 1'b0)  begin bad++; $display("FAIL reset_f_cload: got %b need 0", f_cload); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b need 0", busy); end
      total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b need 0", done); end
      total++; if (s_ready !== 1'b0)  begin bad++; $display("FAIL reset_s_ready: got %b need 0", s_ready); end
      db = done_cnt;
      @(posedge clk); #1;
      repeat (20) begin
         s_valid = 1'(($urandom));
         s_data  = 16'($urandom);
         @(negedge clk);
         if (s_ready !== 1'b0) rdy++;
         if (f_dload !== 2'b11 || f_cload !== 1'b0) strobes++;
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      total++; if (strobes != 0) begin bad++; $display("FAIL idle_strobes: got %0d strobe cycles need 0", strobes); end
      total++; if (rdy != 0)     begin bad++; $display("FAIL idle_s_ready: got %0d ready cycles need 0", rdy); end
      total++; if (done_cnt != db) begin bad++; $display("FAIL idle_done: got %0d pulses need 0", done_cnt - db); end
   endtask

   task automatic test_full_session(input string tag);
      int wb, hb, db, ob, n, errs, lat_errs, first_bad;
      wr_t w;
      fill_stim();
      wb = wq.size(); hb = hsq.size(); db = done_cnt; ob = odd_cnt;
      last_wb = wb;
      pulse_start();
      total++; if (busy !== 1'b1 || s_ready !== 1'b1)
         begin bad++; $display("FAIL %s_busy_after_start: busy=%b s_ready=%b need 1 1", tag, busy, s_ready); end
      drive(0, NW, 100, -1, 1'b0);
      repeat (4) @(posedge clk); #1;
      n = wq.size() - wb;
      total++; if (n != NW) begin bad++; $display("FAIL %s_write_count: got %0d need %0d", tag, n, NW); end
      errs = 0; lat_errs = 0; first_bad = -1;
      for (int k = 0; k < n && k < NW; k++) begin
         w = wq[wb + k];
         if (w.is_data != (k >= NC) || w.addr !== exp_addr(k) || w.dat !== stim[k]) begin
            errs++;
            if (first_bad < 0) first_bad = k;
         end
         if (hb + k >= hsq.size() || w.cyc != hsq[hb + k] + 1) lat_errs++;
      end
      total++; if (errs != 0)
         begin bad++; $display("FAIL %s_write_order: %0d bad writes, first at word %0d, need 0", tag, errs, first_bad); end
      total++; if (lat_errs != 0)
         begin bad++; $display("FAIL %s_write_latency: %0d writes not one cycle after handshake, need 0", tag, lat_errs); end
      if (n > 0) begin
         w = wq[wb + n - 1];
         total++; if (w.cyc - wq[wb].cyc != NW - 1)
            begin bad++; $display("FAIL %s_back_to_back: span %0d cycles need %0d", tag, w.cyc - wq[wb].cyc, NW - 1); end
         total++; if (w.addr !== 14'h270F)
            begin bad++; $display("FAIL %s_last_addr: got %h need 270f", tag, w.addr); end
         total++; if (done_cyc != w.cyc)
            begin bad++; $display("FAIL %s_done_timing: done at %0d need %0d", tag, done_cyc, w.cyc); end
      end
      total++; if (done_cnt - db != 1)
         begin bad++; $display("FAIL %s_done_count: got %0d need 1", tag, done_cnt - db); end
      total++; if (busy !== 1'b0 || s_ready !== 1'b0)
         begin bad++; $display("FAIL %s_idle_after: busy=%b s_ready=%b need 0 0", tag, busy, s_ready); end
      total++; if (odd_cnt != ob)
         begin bad++; $display("FAIL %s_dload_encoding: %0d illegal cycles need 0", tag, odd_cnt - ob); end
   endtask

   task automatic test_block_wrap();
      wr_t a, b;
      if (wq.size() < last_wb + NC + 513) begin
         total++; bad++;
         $display("FAIL block_wrap_log: %0d writes logged, need %0d", wq.size() - last_wb, NC + 513);
      end else begin
         a = wq[last_wb + NC + 511];
         b = wq[last_wb + NC + 512];
         total++; if (a.addr !== 14'h01FF) begin bad++; $display("FAIL wrap_addr_511: got %h need 01ff", a.addr); end
         total++; if (b.addr !== 14'h0200) begin bad++; $display("FAIL wrap_addr_512: got %h need 0200", b.addr); end
         total++; if (b.cyc - a.cyc != 1)  begin bad++; $display("FAIL wrap_consecutive: gap %0d need 1", b.cyc - a.cyc); end
      end
   endtask

   task automatic test_random_gaps();
      int wb, hb, db, ob, n, errs, lat_errs, dups, img_errs;
      wr_t w;
      fill_stim();
      wb = wq.size(); hb = hsq.size(); db = done_cnt; ob = odd_cnt;
      for (int a = 0; a < 16384; a++) dseen[a] = 1'b0;
      for (int a = 0; a < NC; a++) cseen[a] = 1'b0;
      pulse_start();
      drive(0, NW, 50, -1, 1'b0);
      repeat (4) @(posedge clk); #1;
      n = wq.size() - wb;
      total++; if (n != NW) begin bad++; $display("FAIL gaps_write_count: got %0d need %0d", n, NW); end
      errs = 0; lat_errs = 0; dups = 0;
      for (int k = 0; k < n; k++) begin
         w = wq[wb + k];
         if (k >= NW || w.is_data != (k >= NC) || w.addr !== exp_addr(k) || w.dat !== stim[k]) errs++;
         if (hb + k >= hsq.size() || w.cyc != hsq[hb + k] + 1) lat_errs++;
         if (w.is_data) begin
            if (dseen[w.addr]) dups++;
            dseen[w.addr] = 1'b1;
            dimg[w.addr] = w.dat;
         end else if (w.addr < NC) begin
            if (cseen[w.addr]) dups++;
            cseen[w.addr] = 1'b1;
            cimg[w.addr] = w.dat;
         end else begin
            errs++;
         end
      end
      img_errs = 0;
      for (int k = 0; k < NC; k++)
         if (!cseen[k] || cimg[k] !== stim[k]) img_errs++;
      for (int k = NC; k < NW; k++)
         if (!dseen[exp_addr(k)] || dimg[exp_addr(k)] !== stim[k]) img_errs++;
      total++; if (errs != 0)     begin bad++; $display("FAIL gaps_write_order: %0d bad writes need 0", errs); end
      total++; if (lat_errs != 0) begin bad++; $display("FAIL gaps_latency: %0d writes off handshake need 0", lat_errs); end
      total++; if (dups != 0)     begin bad++; $display("FAIL gaps_duplicates: %0d rewritten words need 0", dups); end
      total++; if (img_errs != 0) begin bad++; $display("FAIL gaps_image: %0d wrong words need 0", img_errs); end
      total++; if (done_cnt - db != 1) begin bad++; $display("FAIL gaps_done_count: got %0d need 1", done_cnt - db); end
      total++; if (odd_cnt != ob) begin bad++; $display("FAIL gaps_dload_encoding: %0d illegal cycles need 0", odd_cnt - ob); end
   endtask

   task automatic test_abort();
      int wb, db;
      wr_t w;
      fill_stim();
      wb = wq.size(); db = done_cnt;
      pulse_start();
      drive(0, NW, 100, NC + 300, 1'b0);
      total++; if (busy !== 1'b0 || s_ready !== 1'b0)
         begin bad++; $display("FAIL abort_idle: busy=%b s_ready=%b need 0 0", busy, s_ready); end
      @(negedge clk);
      total++; if (f_dload !== 2'b11 || f_cload !== 1'b0)
         begin bad++; $display("FAIL abort_no_write: dload=%b cload=%b need 11 0", f_dload, f_cload); end
      total++; if (wq.size() - wb != NC + 300)
         begin bad++; $display("FAIL abort_write_count: got %0d need %0d", wq.size() - wb, NC + 300); end
      if (wq.size() > wb) begin
         w = wq[wq.size() - 1];
         total++; if (w.addr !== 14'd299 || w.dat !== stim[NC + 299])
            begin bad++; $display("FAIL abort_last_write: addr=%h dat=%h need 012b %h", w.addr, w.dat, stim[NC + 299]); end
      end
      repeat (5) @(posedge clk); #1;
      total++; if (done_cnt != db) begin bad++; $display("FAIL abort_done: got %0d pulses need 0", done_cnt - db); end
   endtask

   task automatic test_reset_mid();
      int wb, db;
      fill_stim();
      wb = wq.size(); db = done_cnt;
      pulse_start();
      drive(0, NW, 100, NC + 5000, 1'b1);
      @(negedge clk);
      total++; if (f_din !== 16'h0)   begin bad++; $display("FAIL midrst_f_din: got %h need 0000", f_din); end
      total++; if (f_addr !== 14'h0)  begin bad++; $display("FAIL midrst_f_addr: got %h need 0000", f_addr); end
      total++; if (f_dload !== 2'b11) begin bad++; $display("FAIL midrst_f_dload: got %b need 11", f_dload); end
      total++; if (f_cload !== 1'b0)  begin bad++; $display("FAIL midrst_f_cload: got %b need 0", f_cload); end
      total++; if (busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0)
         begin bad++; $display("FAIL midrst_status: busy=%b done=%b s_ready=%b need 0 0 0", busy, done, s_ready); end
      total++; if (wq.size() - wb != NC + 5000)
         begin bad++; $display("FAIL midrst_write_count: got %0d need %0d", wq.size() - wb, NC + 5000); end
      repeat (3) @(posedge clk); #1;
      total++; if (done_cnt != db) begin bad++; $display("FAIL midrst_done: got %0d pulses need 0", done_cnt - db); end
   endtask

   initial begin
      test_reset();
      test_full_session("full");
      test_block_wrap();
      test_random_gaps();
      test_abort();
      test_full_session("reload");
      test_reset_mid();
      test_full_session("after_reset");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: time limit reached with total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
